// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// store_merge_unit
//   Store path for the multicycle CPU: word stores pass straight through,
//   halfword/byte stores read the enclosing word, merge one lane, write back.
// Revision: 1.0
// ============================================================================
module store_merge_unit #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  storeSize,
  input  logic [31:0] addr,
  input  logic [31:0] regData,
  input  logic [31:0] memDataIn,
  output logic [31:0] memAddr,
  output logic [31:0] memDataOut,
  output logic        memWrite,
  output logic        busy,
  output logic        done,
  output logic        storeErr
);

  localparam int             CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]     SIZE_WORD = 2'b00;
  localparam logic [1:0]     SIZE_HALF = 2'b01;
  localparam logic [1:0]     SIZE_BYTE = 2'b10;
  localparam logic [1:0]     SIZE_BAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      wdata_q, wdata_d;

  logic [31:0]      merged_word;
  logic             align_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      size_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
    end
  end

  // Little-endian lane replacement on the word coming back from memory.
  always_comb begin
    merged_word = memDataIn;
    if (size_q == SIZE_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged_word[7:0]   = data_q[7:0];
        2'd1:    merged_word[15:8]  = data_q[7:0];
        2'd2:    merged_word[23:16] = data_q[7:0];
        default: merged_word[31:24] = data_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged_word[31:16] = data_q[15:0];
    end else begin
      merged_word[15:0] = data_q[15:0];
    end
  end

  assign align_err = ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00)) ||
                     ((size_q == SIZE_HALF) && addr_q[0]) ||
                     (size_q == SIZE_BAD);

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CHECK;
          size_d  = storeSize;
          addr_d  = addr;
          data_d  = regData;
        end
      end
      CHECK: begin
        if (align_err) begin
          state_d = ERR;
        end else if (size_q == SIZE_WORD) begin
          state_d = WRITE;
          wdata_d = data_q;
        end else begin
          state_d = READ;
          cnt_d   = CNT_LOAD;
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          state_d = WRITE;
          wdata_d = merged_word;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode the async-reset state register, so reset drops them at once.
  assign memAddr    = {addr_q[31:2], 2'b00};
  assign memDataOut = wdata_q;
  assign memWrite   = (state_q == WRITE);
  assign done       = (state_q == WRITE) || (state_q == ERR);
  assign storeErr   = (state_q == ERR);
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`default_nettype none
// tb_store_merge_unit: directed tests against two instances (MEM_LATENCY 1 and 3)
// sharing one stimulus bus; each has its own memory read word.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  storeSize;
  logic [31:0] addr, regData, mem1, mem3;
  logic [31:0] memAddr1, memDataOut1, memAddr3, memDataOut3;
  logic        memWrite1, busy1, done1, err1;
  logic        memWrite3, busy3, done3, err3;
  int          checks = 0;
  int          errors = 0;

  store_merge_unit #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .storeSize(storeSize), .addr(addr),
    .regData(regData), .memDataIn(mem1), .memAddr(memAddr1), .memDataOut(memDataOut1),
    .memWrite(memWrite1), .busy(busy1), .done(done1), .storeErr(err1));

  store_merge_unit #(.MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .storeSize(storeSize), .addr(addr),
    .regData(regData), .memDataIn(mem3), .memAddr(memAddr3), .memDataOut(memDataOut3),
    .memWrite(memWrite3), .busy(busy3), .done(done3), .storeErr(err3));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start = 1'b0;
    repeat (6) cyc();
  endtask

  // Returns in cycle E+1 (one cycle after the accepting edge).
  task automatic launch(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    storeSize = sz;
    addr      = a;
    regData   = d;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; storeSize = 2'b00; addr = '0; regData = '0;
    mem1 = '0; mem3 = '0;
    cyc(); cyc();
    checks++;
    if ({memWrite1, busy1, done1, err1, memWrite3, busy3, done3, err3} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000000",
               {memWrite1, busy1, done1, err1, memWrite3, busy3, done3, err3});
    end
    checks++;
    if ({memAddr1, memDataOut1, memAddr3, memDataOut3} !== 128'h0) begin
      errors++;
      $display("FAIL reset_bus: got %h %h %h %h want all 0", memAddr1, memDataOut1, memAddr3, memDataOut3);
    end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_sw_aligned();
    launch(2'b00, 32'h0000_0104, 32'hDEAD_BEEF);
    checks++;
    if ({memWrite1, busy1, done1} !== 3'b010 || memAddr1 !== 32'h104) begin
      errors++;
      $display("FAIL sw_check: got we/busy/done=%b addr=%h want 010 addr=104", {memWrite1, busy1, done1}, memAddr1);
    end
    cyc();
    checks++;
    if ({memWrite1, done1, err1} !== 3'b110 || memAddr1 !== 32'h104 || memDataOut1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_write: got we/done/err=%b addr=%h data=%h want 110 104 deadbeef",
               {memWrite1, done1, err1}, memAddr1, memDataOut1);
    end
    checks++;
    if ({memWrite3, done3} !== 2'b11 || memDataOut3 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL sw_write_l3: got we/done=%b data=%h want 11 deadbeef", {memWrite3, done3}, memDataOut3);
    end
    cyc();
    checks++;
    if ({memWrite1, busy1, done1} !== 3'b000 || memAddr1 !== 32'h104) begin
      errors++;
      $display("FAIL sw_after: got we/busy/done=%b addr=%h want 000 addr=104", {memWrite1, busy1, done1}, memAddr1);
    end
    idle();
  endtask

  task automatic test_sb_lane2();
    mem1 = 32'h1122_3344; mem3 = 32'h1122_3344;
    launch(2'b10, 32'h0000_0202, 32'hFFFF_FFAB);
    for (int c = 1; c <= 2; c++) begin
      checks++;
      if ({memWrite1, busy1} !== 2'b01) begin
        errors++;
        $display("FAIL sb_wait c=%0d: got we/busy=%b want 01", c, {memWrite1, busy1});
      end
      cyc();
    end
    checks++;
    if ({memWrite1, done1, err1} !== 3'b110 || memAddr1 !== 32'h200 || memDataOut1 !== 32'h11AB_3344) begin
      errors++;
      $display("FAIL sb_write: got we/done/err=%b addr=%h data=%h want 110 200 11ab3344",
               {memWrite1, done1, err1}, memAddr1, memDataOut1);
    end
    cyc(); cyc();
    checks++;
    if (memWrite3 !== 1'b1 || memDataOut3 !== 32'h11AB_3344 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL sb_write_l3: got we3=%b data3=%h busy1=%b want 1 11ab3344 0", memWrite3, memDataOut3, busy1);
    end
    idle();
  endtask

  task automatic test_sh_upper();
    mem1 = 32'hAAAA_BBBB; mem3 = 32'hAAAA_BBBB;
    launch(2'b01, 32'h0000_0012, 32'h0000_1234);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({memWrite3, busy3} !== 2'b01) begin
        errors++;
        $display("FAIL sh_wait c=%0d: got we/busy=%b want 01", c, {memWrite3, busy3});
      end
      cyc();
    end
    checks++;
    if ({memWrite3, done3, err3} !== 3'b110 || memAddr3 !== 32'h10 || memDataOut3 !== 32'h1234_BBBB) begin
      errors++;
      $display("FAIL sh_write: got we/done/err=%b addr=%h data=%h want 110 10 1234bbbb",
               {memWrite3, done3, err3}, memAddr3, memDataOut3);
    end
    cyc();
    checks++;
    if ({memWrite3, busy3} !== 2'b00) begin
      errors++;
      $display("FAIL sh_after: got we/busy=%b want 00", {memWrite3, busy3});
    end
    idle();
  endtask

  task automatic test_errors();
    logic [1:0]  sizes [3] = '{2'b00, 2'b01, 2'b11};
    logic [31:0] addrs [3] = '{32'h0000_0001, 32'h0000_0003, 32'h0000_0040};
    for (int i = 0; i < 3; i++) begin
      launch(sizes[i], addrs[i], 32'h5555_AAAA);
      checks++;
      if ({memWrite1, busy1, done1, err1} !== 4'b0100) begin
        errors++;
        $display("FAIL err%0d_check: got we/busy/done/err=%b want 0100", i, {memWrite1, busy1, done1, err1});
      end
      cyc();
      checks++;
      if ({memWrite1, done1, err1, memWrite3, done3, err3} !== 6'b011011) begin
        errors++;
        $display("FAIL err%0d_pulse: got %b want 011011", i, {memWrite1, done1, err1, memWrite3, done3, err3});
      end
      cyc();
      checks++;
      if ({memWrite1, busy1, done1, err1, memWrite3, busy3} !== 6'b000000) begin
        errors++;
        $display("FAIL err%0d_after: got %b want 000000", i, {memWrite1, busy1, done1, err1, memWrite3, busy3});
      end
      idle();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_we, exp_busy;
    mem1 = 32'hCAFE_F00D; mem3 = 32'h5566_7788;
    storeSize = 2'b10; addr = 32'h0000_0300; regData = 32'h0000_0011;
    start = 1'b1;
    cyc();
    addr = 32'h0000_0301; regData = 32'h0000_0022;
    for (int c = 1; c <= 8; c++) begin
      exp_we   = (c == 3) || (c == 7);
      exp_busy = !((c == 4) || (c == 8));
      checks++;
      if ({memWrite1, busy1} !== {exp_we, exp_busy}) begin
        errors++;
        $display("FAIL b2b c=%0d: got we/busy=%b want %b", c, {memWrite1, busy1}, {exp_we, exp_busy});
      end
      if (c == 3) begin
        checks++;
        if (memDataOut1 !== 32'hCAFE_F011 || memAddr1 !== 32'h300) begin
          errors++;
          $display("FAIL b2b_first: got addr=%h data=%h want 300 cafef011", memAddr1, memDataOut1);
        end
      end
      if (c == 5) begin
        checks++;
        if (memWrite3 !== 1'b1 || memDataOut3 !== 32'h5566_7711) begin
          errors++;
          $display("FAIL b2b_l3: got we=%b data=%h want 1 55667711", memWrite3, memDataOut3);
        end
        start = 1'b0;
      end
      if (c == 7) begin
        checks++;
        if (memDataOut1 !== 32'hCAFE_220D || memAddr1 !== 32'h300) begin
          errors++;
          $display("FAIL b2b_second: got addr=%h data=%h want 300 cafe220d", memAddr1, memDataOut1);
        end
      end
      cyc();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    mem1 = 32'h0102_0304; mem3 = 32'h0102_0304;
    launch(2'b10, 32'h0000_0401, 32'h0000_009A);
    cyc(); cyc();
    checks++;
    if ({memWrite1, busy3} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre: got we1/busy3=%b want 11", {memWrite1, busy3});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({memWrite1, busy1, done1, memWrite3, busy3, done3} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_async: got %b want 000000", {memWrite1, busy1, done1, memWrite3, busy3, done3});
    end
    #1 reset = 1'b1;
    cyc();
    launch(2'b00, 32'h0000_0500, 32'h1234_5678);
    cyc();
    checks++;
    if ({memWrite1, done1, err1} !== 3'b110 || memAddr1 !== 32'h500 || memDataOut1 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rst_resume: got we/done/err=%b addr=%h data=%h want 110 500 12345678",
               {memWrite1, done1, err1}, memAddr1, memDataOut1);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sw_aligned();
    test_sb_lane2();
    test_sh_upper();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_merge_unit.md
# store_merge_unit

Multi-cycle store path of the multicycle CPU: takes a register operand, a byte address and a store size, and writes it to data memory as a full 32-bit word. Word stores go straight out. Halfword and byte stores do a read-modify-write: read the enclosing word, merge the new lane, write the word back. The block sits between the register-B/ALU-result registers and the memory write port, and runs alongside the write-back mux that feeds the register file.

## Interface
- MEM_LATENCY, default 1: cycles from a stable memAddr to valid memDataIn; must be ≥1.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- start  input  1  request a store; sampled only in IDLE.
- storeSize  input  2  00 word (sw), 01 halfword (sh), 10 byte (sb), 11 illegal.
- addr  input  32  byte address of the store.
- regData  input  32  store operand; sh uses [15:0], sb uses [7:0].
- memDataIn  input  32  memory read data.
- memAddr  output  32  word-aligned address, {addrLatched[31:2],2'b00}.
- memDataOut  output  32  write data.
- memWrite  output  1  memory write enable, one cycle per store.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the store (or its rejection) completes.
- storeErr  output  1  one-cycle pulse, coincident with done, for a misaligned or illegal store.

## Operation
- Lane mapping is little-endian.
  - Byte k occupies bits [8k+7:8k], with k = addr[1:0].
  - Halfword occupies [15:0] when addr[1]=0 and [31:16] when addr[1]=1.
- On an accepted start (IDLE, start=1), latch storeSize, addr and regData. Later changes on these inputs are ignored until return to IDLE.
- Alignment check is performed on the latched values, in the first cycle after acceptance:
  - sw with addr[1:0]≠00 → ERR.
  - sh with addr[0]=1 → ERR.
  - storeSize=11 → ERR.
- States:
  - IDLE: busy=0; on start → CHECK.
  - CHECK: one cycle; drives memAddr.
    - Error → ERR.
    - sw → WRITE.
    - sh/sb → READ with the wait counter loaded to MEM_LATENCY-1.
  - READ: memWrite=0, memAddr held.
    - Counter decrements each cycle.
    - At counter=0, capture memDataIn into the merge register → WRITE.
  - WRITE: memWrite=1, done=1 for exactly one cycle → IDLE.
    - memDataOut = regData for sw.
    - memDataOut = the captured word with only the selected lane replaced for sh/sb. All other bits come unchanged from memory.
  - ERR: done=1, storeErr=1, memWrite=0 for one cycle → IDLE. Memory is never written.
- start while busy is ignored; it is not queued.
- start asserted in the same cycle that WRITE/ERR returns to IDLE is not accepted. It must be held, or re-asserted, while in IDLE.

## Timing
- Reset values: state IDLE, memAddr=0, memDataOut=0, memWrite=0, busy=0, done=0, storeErr=0, counter and latches 0.
- Reset asserted mid-operation clears memWrite and done immediately (asynchronously), with no partial write. Deasserting reset resumes in IDLE.
- Let edge E be the edge at which start is accepted. Then:
  - sw: CHECK in cycle E+1, WRITE in cycle E+2 (memWrite and done high), IDLE in E+3.
  - sh/sb: READ covers cycles E+2 … E+1+MEM_LATENCY. WRITE falls in cycle E+2+MEM_LATENCY.
  - ERR: in cycle E+2; no memWrite.
- memAddr is stable from CHECK through WRITE inclusive. It holds its last value while in IDLE.
- memDataOut is valid only while memWrite=1; otherwise it holds its last value.
- Minimum spacing between accepted starts: 3 cycles for sw, 3+MEM_LATENCY cycles for sh/sb.

## Test plan
- Reset: pulse reset low mid-READ of an sb → memWrite, busy and done drop at once. The next start is accepted normally.
- sw aligned: addr=0x0000_0104, regData=0xDEAD_BEEF → single memWrite at cycle E+2 with memAddr=0x104, memDataOut=0xDEADBEEF, done=1, storeErr=0.
- sb lane 2, MEM_LATENCY=1: memory word 0x1122_3344, addr=0x0000_0202, regData=0xFFFF_FFAB → write 0x11AB_3344 to 0x200 at cycle E+3.
- sh upper, MEM_LATENCY=3: memory word 0xAAAA_BBBB, addr=0x0000_0012, regData=0x0000_1234 → write 0x1234_BBBB to 0x10 at cycle E+5.
- Errors, one per case: sw at 0x0000_0001, sh at 0x0000_0003, storeSize=11 → storeErr=done=1 at cycle E+2; memWrite never asserted.
- Busy behaviour: start held high continuously for a stream of sb stores → each accepted only from IDLE. Inputs changed mid-operation do not affect the in-flight write.
